// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//
// Sequences one image-sensor frame: erase the pixel array, integrate for a
// programmable exposure, run the ADC ramp, then present each row for readout
// with a valid/ready handshake, and finally pulse frame_done.
//
// Ports
//   clk             rising-edge clock for all logic
//   reset           synchronous, active-high reset
//   start           frame request, honoured only in IDLE
//   abort           drop the current frame and go back to IDLE
//   expose_time     exposure length in cycles, latched at start (0 acts as 1)
//   row_ready       downstream accepts the row currently presented
//   erase           pixel erase strobe
//   expose          pixel integrate strobe
//   adc_enable      ADC ramp/convert enable
//   decoder_select  one-hot row select, all zero outside READ
//   row_valid       a row is being presented for readout
//   busy            high in every state except IDLE
//   frame_done      one-cycle end-of-frame pulse
//
// Parameters
//   ROWS            number of pixel rows (width of decoder_select)
//   ERASE_CYCLES    erase pulse length in cycles (1..255)
//   CONVERT_CYCLES  ADC ramp length in cycles (1..255)
//
// Build option
//   PIXEL_FRAME_CONTINUOUS_EN  when defined, a start seen in DONE chains
//                              straight into the next frame's ERASE and
//                              re-latches expose_time; otherwise every frame
//                              returns to IDLE for at least one cycle.

module pixel_frame_sequencer #(
    parameter int ROWS           = 10,
    parameter int ERASE_CYCLES   = 4,
    parameter int CONVERT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [7:0]      expose_time,
    input  logic            row_ready,
    output logic            erase,
    output logic            expose,
    output logic            adc_enable,
    output logic [ROWS-1:0] decoder_select,
    output logic            row_valid,
    output logic            busy,
    output logic            frame_done
);

    localparam int              ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(ROWS - 1);
    localparam logic [7:0]      ERASE_LOAD   = 8'(ERASE_CYCLES);
    localparam logic [7:0]      CONVERT_LOAD = 8'(CONVERT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       count;
    logic [7:0]       count_next;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_next;
    logic [7:0]       exposure;
    logic [7:0]       exposure_next;
    logic [7:0]       expose_clamped;

    // A zero exposure request still integrates for one cycle.
    assign expose_clamped = (expose_time == 8'd0) ? 8'd1 : expose_time;

    // Next-state logic. The counter is loaded with the full duration on entry
    // to each timed state and counts down; the state is left on the cycle the
    // counter reads 1 (the <= guard keeps a corrupted zero from stalling).
    // Abort outranks everything else once a frame is in flight.
    always_comb begin
        state_next    = state;
        count_next    = count;
        row_next      = row;
        exposure_next = exposure;

        if ((state != IDLE) && abort) begin
            state_next = IDLE;
            count_next = 8'd0;
            row_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next    = ERASE;
                        count_next    = ERASE_LOAD;
                        exposure_next = expose_clamped;
                    end
                end
                ERASE: begin
                    if (count <= 8'd1) begin
                        state_next = EXPOSE;
                        count_next = exposure;
                    end else begin
                        count_next = count - 8'd1;
                    end
                end
                EXPOSE: begin
                    if (count <= 8'd1) begin
                        state_next = CONVERT;
                        count_next = CONVERT_LOAD;
                    end else begin
                        count_next = count - 8'd1;
                    end
                end
                CONVERT: begin
                    if (count <= 8'd1) begin
                        state_next = READ;
                        count_next = 8'd0;
                        row_next   = '0;
                    end else begin
                        count_next = count - 8'd1;
                    end
                end
                READ: begin
                    // row_valid is high for the whole of READ, so row_ready
                    // alone marks a completed handshake.
                    if (row_ready) begin
                        if (row == LAST_ROW) begin
                            state_next = DONE;
                            row_next   = '0;
                        end else begin
                            row_next = row + 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef PIXEL_FRAME_CONTINUOUS_EN
                    if (start) begin
                        state_next    = ERASE;
                        count_next    = ERASE_LOAD;
                        exposure_next = expose_clamped;
                    end else begin
                        state_next = IDLE;
                        count_next = 8'd0;
                    end
`else
                    state_next = IDLE;
                    count_next = 8'd0;
`endif
                end
                default: begin
                    state_next = IDLE;
                    count_next = 8'd0;
                    row_next   = '0;
                end
            endcase
        end
    end

    // State and outputs are registered together. Outputs are decoded from the
    // next state so they line up with the state they describe, which also
    // guarantees only one of the strobes/row_valid is ever high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= 8'd0;
            row            <= '0;
            exposure       <= 8'd1;
            erase          <= 1'b0;
            expose         <= 1'b0;
            adc_enable     <= 1'b0;
            decoder_select <= '0;
            row_valid      <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            row            <= row_next;
            exposure       <= exposure_next;
            erase          <= (state_next == ERASE);
            expose         <= (state_next == EXPOSE);
            adc_enable     <= (state_next == CONVERT);
            decoder_select <= (state_next == READ) ? (ROWS'(1) << row_next) : '0;
            row_valid      <= (state_next == READ);
            busy           <= (state_next != IDLE);
            frame_done     <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// tb_pixel_frame_sequencer
//
// Drives pixel_frame_sequencer (ROWS=10, ERASE_CYCLES=4, CONVERT_CYCLES=8)
// one clock at a time. Each step pushes the output vector expected after the
// next rising edge onto a queue; the vector is popped and compared 1 time
// unit after that edge. Whole frames come from a table of records; abort,
// reset, row stalls and back-to-back frames are hand-written sequences.

module tb_pixel_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] expose_time;
    logic       row_ready;
    logic       erase;
    logic       expose;
    logic       adc_enable;
    logic [9:0] decoder_select;
    logic       row_valid;
    logic       busy;
    logic       frame_done;

    int compared   = 0;
    int mismatched = 0;

    typedef enum int {P_IDLE, P_ERASE, P_EXPOSE, P_ADC, P_READ, P_DONE} phase_e;

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       adc;
        logic [9:0] dec;
        logic       rv;
        logic       busy;
        logic       fd;
    } out_t;

    typedef struct {
        string      name;
        logic       start;
        logic [7:0] et;
        int         reps;
        out_t       exp;
    } vec_t;

    out_t exp_q[$];
    vec_t vecs[$];

    pixel_frame_sequencer #(
        .ROWS(10),
        .ERASE_CYCLES(4),
        .CONVERT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .expose_time(expose_time),
        .row_ready(row_ready),
        .erase(erase),
        .expose(expose),
        .adc_enable(adc_enable),
        .decoder_select(decoder_select),
        .row_valid(row_valid),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected output vector for each phase of a frame.
    function automatic out_t expOut(input phase_e p, input int r);
        out_t o;
        logic [9:0] one;
        o   = '0;
        one = 10'b1;
        case (p)
            P_ERASE:  begin o.erase = 1'b1; o.busy = 1'b1; end
            P_EXPOSE: begin o.expose = 1'b1; o.busy = 1'b1; end
            P_ADC:    begin o.adc = 1'b1; o.busy = 1'b1; end
            P_READ:   begin o.dec = one << r; o.rv = 1'b1; o.busy = 1'b1; end
            P_DONE:   begin o.fd = 1'b1; o.busy = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string n);
        out_t e;
        out_t a;
        a = '{erase, expose, adc_enable, decoder_select, row_valid, busy, frame_done};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b but scoreboard queue was empty", n, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b expected %b (erase,expose,adc,dec[9:0],rv,busy,fd)",
                         n, a, e);
            end
        end
    endtask

    task automatic applyStimulus(input string n, input logic s, input logic a,
                                 input logic [7:0] et, input logic rr,
                                 input logic rst, input out_t e);
        start       = s;
        abort       = a;
        expose_time = et;
        row_ready   = rr;
        reset       = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(n);
    endtask

    task automatic addVec(input string n, input logic s, input logic [7:0] et,
                          input int reps, input out_t e);
        vec_t v;
        v.name  = n;
        v.start = s;
        v.et    = et;
        v.reps  = reps;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // A full frame: stray starts during ERASE and a changed expose_time after
    // latching must not disturb it.
    task automatic addFrame(input string n, input logic [7:0] et, input logic [7:0] et_later);
        int exp_len;
        exp_len = (et == 8'd0) ? 1 : int'(et);
        addVec({n, " erase-entry"}, 1'b1, et, 1, expOut(P_ERASE, 0));
        addVec({n, " erase"}, 1'b1, et_later, 3, expOut(P_ERASE, 0));
        addVec({n, " expose"}, 1'b0, et_later, exp_len, expOut(P_EXPOSE, 0));
        addVec({n, " convert"}, 1'b0, et_later, 8, expOut(P_ADC, 0));
        for (int r = 0; r < 10; r++)
            addVec($sformatf("%s read row %0d", n, r), 1'b0, et_later, 1, expOut(P_READ, r));
        addVec({n, " done"}, 1'b0, et_later, 1, expOut(P_DONE, 0));
        addVec({n, " idle"}, 1'b0, et_later, 2, expOut(P_IDLE, 0));
    endtask

    // Start a frame and run it up to (but not into) READ, checking each cycle.
    task automatic runToRead(input string n, input logic s_hold, input logic [7:0] et,
                             input int adc_steps);
        int exp_len;
        exp_len = (et == 8'd0) ? 1 : int'(et);
        applyStimulus({n, " erase-entry"}, 1'b1, 1'b0, et, 1'b1, 1'b0, expOut(P_ERASE, 0));
        for (int i = 0; i < 3; i++)
            applyStimulus({n, " erase"}, s_hold, 1'b0, et, 1'b1, 1'b0, expOut(P_ERASE, 0));
        for (int i = 0; i < exp_len; i++)
            applyStimulus({n, " expose"}, s_hold, 1'b0, et, 1'b1, 1'b0, expOut(P_EXPOSE, 0));
        for (int i = 0; i < adc_steps; i++)
            applyStimulus({n, " convert"}, s_hold, 1'b0, et, 1'b1, 1'b0, expOut(P_ADC, 0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        expose_time = 8'd0;
        row_ready   = 1'b1;

        addFrame("frameA", 8'd5, 8'd200);
        addFrame("frameB", 8'd0, 8'd7);

        // Reset wins over start and abort.
        applyStimulus("reset0", 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, expOut(P_IDLE, 0));
        applyStimulus("reset1", 1'b1, 1'b0, 8'd5, 1'b1, 1'b1, expOut(P_IDLE, 0));
        applyStimulus("idle-after-reset", 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, expOut(P_IDLE, 0));

        foreach (vecs[i])
            for (int k = 0; k < vecs[i].reps; k++)
                applyStimulus(vecs[i].name, vecs[i].start, 1'b0, vecs[i].et, 1'b1, 1'b0,
                              vecs[i].exp);

        // Downstream stalls on row 2 for three cycles, then a mid-READ abort.
        runToRead("stall", 1'b0, 8'd1, 8);
        applyStimulus("stall row0", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_READ, 0));
        applyStimulus("stall row1", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_READ, 1));
        applyStimulus("stall row2", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_READ, 2));
        for (int i = 0; i < 3; i++)
            applyStimulus("stall row2 held", 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, expOut(P_READ, 2));
        applyStimulus("stall row3", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_READ, 3));
        applyStimulus("abort in read", 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, expOut(P_IDLE, 0));
        applyStimulus("idle after read abort", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_IDLE, 0));

        // Abort on the second CONVERT cycle with start also high.
        runToRead("abort", 1'b0, 8'd2, 2);
        applyStimulus("abort in convert", 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, expOut(P_IDLE, 0));
        for (int i = 0; i < 3; i++)
            applyStimulus("idle after convert abort", 1'b0, 1'b0, 8'd2, 1'b1, 1'b0,
                          expOut(P_IDLE, 0));

        // Reset while row 5 is presented; the next frame starts clean.
        runToRead("rst", 1'b0, 8'd1, 8);
        for (int r = 0; r < 6; r++)
            applyStimulus($sformatf("rst read row %0d", r), 1'b0, 1'b0, 8'd1, 1'b1, 1'b0,
                          expOut(P_READ, r));
        applyStimulus("reset in read", 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, expOut(P_IDLE, 0));
        applyStimulus("idle after reset", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_IDLE, 0));
        applyStimulus("still idle", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, expOut(P_IDLE, 0));
        runToRead("post-rst", 1'b0, 8'd3, 8);
        applyStimulus("post-rst row0", 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, expOut(P_READ, 0));
        applyStimulus("post-rst row1", 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, expOut(P_READ, 1));
        applyStimulus("post-rst abort", 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, expOut(P_IDLE, 0));

        // start held high across the end of a frame.
        runToRead("held", 1'b1, 8'd2, 8);
        for (int r = 0; r < 10; r++)
            applyStimulus($sformatf("held read row %0d", r), 1'b1, 1'b0, 8'd2, 1'b1, 1'b0,
                          expOut(P_READ, r));
        applyStimulus("held done", 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, expOut(P_DONE, 0));
`ifdef PIXEL_FRAME_CONTINUOUS_EN
        applyStimulus("held chain erase", 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, expOut(P_ERASE, 0));
`else
        applyStimulus("held gap idle", 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, expOut(P_IDLE, 0));
`endif
        applyStimulus("held next erase", 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, expOut(P_ERASE, 0));
        applyStimulus("held abort", 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, expOut(P_IDLE, 0));
        applyStimulus("held final idle", 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, expOut(P_IDLE, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
